// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Holds the op and state encodings plus the iteration-counter sizing helper.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } mdu_state_e;

    localparam int MDU_WIDTH = 32;

    // Counter must hold 0..WIDTH-1 with a spare bit of headroom
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Control/data bundle between the core and the multiply/divide unit.
// The core (master) launches operations and MTHI/MTLO writes; the unit (slave) returns HI/LO.
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_absneg.sv
// Conditional two's-complement negate, used both to take operand magnitudes
// and to restore the sign of results.
module mdu_absneg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] din,
    input  logic             neg,
    output logic [WIDTH-1:0] dout
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    assign dout = neg ? (~din + ONE) : din;
endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Works on magnitudes for WIDTH cycles, then fixes signs and writes HI/LO in one cycle.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input logic  clk,
    input logic  rst_n,
    mdu_if.slave bus
);
    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mdu_state_e       state_r;
    mdu_state_e       state_s;
    logic [CNT_W-1:0] cnt_r;
    logic             is_div_r;
    logic             sign_a_r;
    logic             sign_b_r;
    logic             div_zero_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] opnd_r;
    logic [WIDTH-1:0] acc_hi_r;
    logic [WIDTH-1:0] acc_lo_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic               signed_op_s;
    logic               neg_a_s;
    logic               neg_b_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH-1:0]   div_diff_s;
    logic               div_ge_s;
    logic [WIDTH-1:0]   acc_hi_nx_s;
    logic [WIDTH-1:0]   acc_lo_nx_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   quot_fix_s;
    logic [WIDTH-1:0]   rem_fix_s;

    assign signed_op_s = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
    assign neg_a_s     = signed_op_s & bus.a[WIDTH-1];
    assign neg_b_s     = signed_op_s & bus.b[WIDTH-1];

    mdu_absneg #(.WIDTH(WIDTH)) u_abs_a (.din(bus.a), .neg(neg_a_s), .dout(mag_a_s));
    mdu_absneg #(.WIDTH(WIDTH)) u_abs_b (.din(bus.b), .neg(neg_b_s), .dout(mag_b_s));

    // Quotient and product take the XOR of the signs; remainder follows the dividend
    mdu_absneg #(.WIDTH(2*WIDTH)) u_fix_prod (
        .din({acc_hi_r, acc_lo_r}), .neg(sign_a_r ^ sign_b_r), .dout(prod_fix_s));
    mdu_absneg #(.WIDTH(WIDTH)) u_fix_quot (
        .din(acc_lo_r), .neg(sign_a_r ^ sign_b_r), .dout(quot_fix_s));
    mdu_absneg #(.WIDTH(WIDTH)) u_fix_rem (
        .din(acc_hi_r), .neg(sign_a_r), .dout(rem_fix_s));

    // One shift-add (multiply) or restoring-subtract (divide) step
    always_comb begin
        mul_sum_s   = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        div_shift_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
        div_ge_s    = div_shift_s >= {1'b0, opnd_r};
        div_diff_s  = div_shift_s[WIDTH-1:0] - opnd_r;
        if (is_div_r) begin
            acc_hi_nx_s = div_ge_s ? div_diff_s : div_shift_s[WIDTH-1:0];
            acc_lo_nx_s = {acc_lo_r[WIDTH-2:0], div_ge_s};
        end else begin
            acc_hi_nx_s = mul_sum_s[WIDTH:1];
            acc_lo_nx_s = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
        end
    end

    // Next-state logic for IDLE -> CALC (WIDTH steps) -> FIX -> IDLE
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (bus.start) state_s = S_CALC;
                else           state_s = S_IDLE;
            end
            S_CALC: begin
                if (cnt_r == LAST_CNT) state_s = S_FIX;
                else                   state_s = S_CALC;
            end
            S_FIX:   state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State, datapath and architectural HI/LO registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            is_div_r   <= 1'b0;
            sign_a_r   <= 1'b0;
            sign_b_r   <= 1'b0;
            div_zero_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            opnd_r     <= {WIDTH{1'b0}};
            acc_hi_r   <= {WIDTH{1'b0}};
            acc_lo_r   <= {WIDTH{1'b0}};
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != S_IDLE);
            done_r  <= (state_r == S_FIX);
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        // Multiply: multiplier shifts through acc_lo; divide: dividend does
                        is_div_r   <= bus.op[1];
                        sign_a_r   <= neg_a_s;
                        sign_b_r   <= neg_b_s;
                        div_zero_r <= (bus.b == {WIDTH{1'b0}});
                        opnd_r     <= bus.op[1] ? mag_b_s : mag_a_s;
                        acc_hi_r   <= {WIDTH{1'b0}};
                        acc_lo_r   <= bus.op[1] ? mag_a_s : mag_b_s;
                        cnt_r      <= {CNT_W{1'b0}};
                    end else begin
                        if (bus.hi_we) hi_r <= bus.wdata;
                        if (bus.lo_we) lo_r <= bus.wdata;
                    end
                end
                S_CALC: begin
                    acc_hi_r <= acc_hi_nx_s;
                    acc_lo_r <= acc_lo_nx_s;
                    cnt_r    <= cnt_r + CNT_ONE;
                end
                S_FIX: begin
                    if (is_div_r) begin
                        hi_r <= rem_fix_s;
                        lo_r <= div_zero_r ? {WIDTH{1'b1}} : quot_fix_s;
                    end else begin
                        hi_r <= prod_fix_s[2*WIDTH-1:WIDTH];
                        lo_r <= prod_fix_s[WIDTH-1:0];
                    end
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_mult_div_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    mdu_if #(.WIDTH(W)) bus ();

    mult_div_unit #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference result {hi, lo} computed with 64-bit arithmetic
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa;
        longint sb;
        logic [31:0] q;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: return 64'(sa * sb);
            2'd1: return {32'd0, a} * {32'd0, b};
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (op == 2'd2) begin
                    q = 32'(sa / sb);
                    r = 32'(sa % sb);
                end else begin
                    q = a / b;
                    r = a % b;
                end
                return {r, q};
            end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb);
        logic [63:0] exp;
        logic [31:0] hi0;
        logic [31:0] lo0;
        int n;
        int busy_n;
        exp = ref_model(op, a, b);
        @(negedge clk);
        hi0 = bus.hi;
        lo0 = bus.lo;
        bus.start = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        busy_n = 0;
        while (!bus.done && n < 100) begin
            if (bus.busy) busy_n++;
            if (disturb && n == 5) begin
                bus.start = 1'b1;
                bus.op = ~op;
                bus.a = ~a;
                bus.b = b + 32'd1;
                bus.hi_we = 1'b1;
                bus.lo_we = 1'b1;
                bus.wdata = 32'hDEAD_BEEF;
            end else begin
                bus.start = 1'b0;
                bus.hi_we = 1'b0;
                bus.lo_we = 1'b0;
            end
            if (n == 20) check_eq("hold_hilo", {bus.hi, bus.lo}, {hi0, lo0});
            @(negedge clk);
            n++;
        end
        check_eq("busy_cycles", 64'(busy_n), 64'd33);
        check_eq("done_cycle", 64'(n), 64'd34);
        check_eq("result", {bus.hi, bus.lo}, exp);
        check_eq("busy_at_done", 64'(bus.busy), 64'd0);
        @(negedge clk);
        check_eq("done_pulse", 64'(bus.done), 64'd0);
    endtask

    initial begin
        int done_seen;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.op = 2'd0;
        bus.a = 32'd0;
        bus.b = 32'd0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = 32'd0;
        repeat (3) @(negedge clk);
        check_eq("reset_state", {31'd0, bus.busy, bus.done, bus.hi, bus.lo[30:0]}, 64'd0);
        check_eq("reset_lo", 64'(bus.lo), 64'd0);
        rst_n = 1'b1;

        // MTHI / MTLO while idle
        @(negedge clk);
        bus.hi_we = 1'b1;
        bus.wdata = 32'h0000_1234;
        @(negedge clk);
        bus.hi_we = 1'b0;
        check_eq("mthi", 64'(bus.hi), 64'h1234);
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0000_5678;
        @(negedge clk);
        bus.lo_we = 1'b0;
        check_eq("mtlo", 64'(bus.lo), 64'h5678);
        check_eq("mtlo_hi_kept", 64'(bus.hi), 64'h1234);

        // Directed corner cases
        run_op(2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
        check_eq("mult_neg3x5", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check_eq("multu_max", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check_eq("div_neg7_2", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'd3, 32'd100, 32'd7, 1'b0);
        check_eq("divu_100_7", {bus.hi, bus.lo}, {32'd2, 32'd14});
        run_op(2'd3, 32'd100, 32'd0, 1'b0);
        check_eq("divu_by_zero", {bus.hi, bus.lo}, {32'd100, 32'hFFFF_FFFF});
        run_op(2'd2, 32'hFFFF_FF9C, 32'd0, 1'b0);
        check_eq("div_neg_by_zero", {bus.hi, bus.lo}, {32'hFFFF_FF9C, 32'hFFFF_FFFF});
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check_eq("div_minint_m1", {bus.hi, bus.lo}, {32'd0, 32'h8000_0000});

        // Start and MTHI/MTLO during an operation are ignored
        run_op(2'd0, 32'd1234, 32'hFFFF_FF00, 1'b1);

        // Reset mid-operation aborts without a result
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = 2'd1;
        bus.a = 32'd77;
        bus.b = 32'd99;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("abort_busy", 64'(bus.busy), 64'd0);
        check_eq("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) done_seen++;
            @(negedge clk);
        end
        check_eq("abort_no_done", 64'(done_seen), 64'd0);
        run_op(2'd1, 32'd77, 32'd99, 1'b0);

        // Randomized operations with boosted corner operands
        for (int k = 0; k < 30; k++) begin
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       ra = 32'h8000_0000;
                1:       ra = 32'($urandom_range(0, 20));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
